// File: rtl/fetch_prefetch_pkg.sv
// rtl/fetch_prefetch_pkg.sv - shared MIPS fetch definitions: state encoding, opcode field, halt opcode
package fetch_prefetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   localparam int OP_CODE_HI = 31;
   localparam int OP_CODE_LO = 26;
   localparam int OP_CODE_W  = OP_CODE_HI - OP_CODE_LO + 1;

   localparam logic [OP_CODE_W-1:0] HALT_OP_DEFAULT = 6'b111111;

   localparam logic [1:0] PC_SRC_REGISTER = 2'd0;
   localparam logic [1:0] PC_SRC_JUMP     = 2'd1;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - fetch queue: power-of-two depth FIFO with synchronous flush
module fetch_fifo #(
   parameter int WIDTH = 39,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = AW + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Data storage carries no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clock) begin
      if (push && !flush) begin
         storage[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_data = storage[rd_ptr];
   assign empty     = (count == '0);

endmodule

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - instruction prefetcher: PC, 1-cycle instruction memory, fetch queue, halt/redirect FSM
module fetch_prefetch
   import fetch_prefetch_pkg::*;
#(
   parameter int                   NB_DATA = 32,
   parameter int                   NB_ADDR = 7,
   parameter int                   DEPTH   = 4,
   parameter int                   PC_STEP = 4,
   parameter logic [OP_CODE_W-1:0] HALT_OP = HALT_OP_DEFAULT
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               enable_i,
   input  logic               en_write_i,
   input  logic [NB_ADDR-1:0] addr_i_write,
   input  logic [NB_DATA-1:0] data_i,
   input  logic               redirect_i,
   input  logic [1:0]         pc_src,
   input  logic [NB_ADDR-1:0] address_register,
   input  logic [NB_ADDR-1:0] address_jump,
   input  logic [NB_ADDR-1:0] address_branch,
   output logic               instr_valid_o,
   input  logic               instr_ready_i,
   output logic [NB_DATA-1:0] instruction_o,
   output logic [NB_ADDR-1:0] pc_o,
   output logic               halted_o
);

   localparam int                 AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                 CW   = AW + 1;
   localparam logic [NB_ADDR-1:0] STEP = NB_ADDR'(PC_STEP);
   localparam logic [CW:0]        CAP  = (CW+1)'(DEPTH);

   fetch_state_e state_q;
   fetch_state_e state_d;

   logic [NB_DATA-1:0] imem [2**NB_ADDR];
   logic [NB_DATA-1:0] rd_data_q;
   logic [NB_ADDR-1:0] pc_q;
   logic               inflight_q;
   logic [NB_ADDR-1:0] inflight_pc_q;
   logic [NB_ADDR-1:0] target;

   logic                       issue;
   logic                       push;
   logic                       pop;
   logic                       halt_push;
   logic                       room;
   logic                       fifo_empty;
   logic [CW-1:0]              fifo_count;
   logic [CW:0]                occupancy;
   logic [NB_ADDR+NB_DATA-1:0] fifo_head;

   always_comb begin
      case (pc_src)
         PC_SRC_REGISTER: target = address_register;
         PC_SRC_JUMP:     target = address_jump;
         default:         target = address_branch;
      endcase
   end

   // Any read in flight already owns a queue slot so a push can never hit a full queue.
   assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
   assign room      = (occupancy < CAP);
   assign push      = inflight_q && !redirect_i;
   assign halt_push = push && (rd_data_q[OP_CODE_HI:OP_CODE_LO] == HALT_OP);
   assign pop       = instr_valid_o && instr_ready_i;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (redirect_i) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_IDLE:   if (enable_i) state_d = ST_RUN;
            ST_RUN:    if (halt_push) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Enable in IDLE counts as running, so the first read goes out on the same edge that leaves IDLE.
   always_comb begin
      issue    = 1'b0;
      halted_o = (state_q == ST_HALTED);
      if ((state_q == ST_RUN) || (state_q == ST_IDLE)) begin
         issue = enable_i && !redirect_i && room && !halt_push;
      end
   end

   // Write and read share an edge; the nonblocking read returns the pre-write word.
   always_ff @(posedge clock_i) begin
      if (en_write_i) imem[addr_i_write] <= data_i;
      if (issue)      rd_data_q <= imem[pc_q];
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         pc_q          <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else if (redirect_i) begin
         pc_q          <= target;
         inflight_q    <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            pc_q          <= pc_q + STEP;
            inflight_pc_q <= pc_q + STEP;
         end
      end
   end

   fetch_fifo #(
      .WIDTH (NB_ADDR + NB_DATA),
      .DEPTH (DEPTH)
   ) u_fetch_fifo (
      .clock     (clock_i),
      .reset     (reset_i),
      .flush     (redirect_i),
      .push      (push),
      .push_data ({inflight_pc_q, rd_data_q}),
      .pop       (pop),
      .head_data (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign instr_valid_o = !fifo_empty;
   assign instruction_o = instr_valid_o ? fifo_head[NB_DATA-1:0] : '0;
   assign pc_o          = instr_valid_o ? fifo_head[NB_ADDR+NB_DATA-1:NB_DATA] : '0;

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb/tb_fetch_prefetch.sv - scoreboard bench for fetch_prefetch (default and 4-bit address instances)
module tb_fetch_prefetch;

   typedef struct {
      logic [31:0] instr;
      logic [6:0]  pc;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        en_write;
   logic [6:0]  addr_write;
   logic [31:0] data;
   logic        redirect;
   logic [1:0]  pc_src;
   logic [6:0]  addr_reg;
   logic [6:0]  addr_jump;
   logic [6:0]  addr_branch;
   logic        instr_ready;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [6:0]  pc;
   logic        halted;

   logic        enable2;
   logic        en_write2;
   logic [3:0]  addr_write2;
   logic        redirect2;
   logic [3:0]  addr_reg2;
   logic [3:0]  addr_jump2;
   logic [3:0]  addr_branch2;
   logic        instr_valid2;
   logic [31:0] instruction2;
   logic [3:0]  pc2;
   logic        halted2;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];
   exp_t exp2_q[$];
   exp_t e;

   localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

   always #5 clock = ~clock;

   fetch_prefetch dut (
      .clock_i          (clock),
      .reset_i          (reset),
      .enable_i         (enable),
      .en_write_i       (en_write),
      .addr_i_write     (addr_write),
      .data_i           (data),
      .redirect_i       (redirect),
      .pc_src           (pc_src),
      .address_register (addr_reg),
      .address_jump     (addr_jump),
      .address_branch   (addr_branch),
      .instr_valid_o    (instr_valid),
      .instr_ready_i    (instr_ready),
      .instruction_o    (instruction),
      .pc_o             (pc),
      .halted_o         (halted)
   );

   fetch_prefetch #(.NB_ADDR(4)) dut2 (
      .clock_i          (clock),
      .reset_i          (reset),
      .enable_i         (enable2),
      .en_write_i       (en_write2),
      .addr_i_write     (addr_write2),
      .data_i           (data),
      .redirect_i       (redirect2),
      .pc_src           (pc_src),
      .address_register (addr_reg2),
      .address_jump     (addr_jump2),
      .address_branch   (addr_branch2),
      .instr_valid_o    (instr_valid2),
      .instr_ready_i    (instr_ready),
      .instruction_o    (instruction2),
      .pc_o             (pc2),
      .halted_o         (halted2)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic exp_push(input logic [31:0] instr_v, input logic [6:0] pc_v);
      exp_t x;
      x.instr = instr_v;
      x.pc    = pc_v;
      exp_q.push_back(x);
   endtask

   task automatic exp2_push(input logic [31:0] instr_v, input logic [6:0] pc_v);
      exp_t x;
      x.instr = instr_v;
      x.pc    = pc_v;
      exp2_q.push_back(x);
   endtask

   // Program image: 0x20000001.. at 0..28, halt at 32.
   task automatic exp_stream(input int start_addr);
      for (int a = start_addr; a <= 28; a += 4) begin
         exp_push(32'h2000_0001 + 32'(a / 4), 7'(a + 4));
      end
      exp_push(HALT_WORD, 7'd36);
   endtask

   task automatic wr(input logic [6:0] a, input logic [31:0] d);
      en_write   = 1'b1;
      addr_write = a;
      data       = d;
      step();
      en_write   = 1'b0;
   endtask

   task automatic wr2(input logic [3:0] a, input logic [31:0] d);
      en_write2   = 1'b1;
      addr_write2 = a;
      data        = d;
      step();
      en_write2   = 1'b0;
   endtask

   task automatic redirect_to(input logic [1:0] src, input logic [6:0] target);
      pc_src      = src;
      addr_reg    = target;
      addr_jump   = target;
      addr_branch = target;
      redirect    = 1'b1;
      step();
      redirect    = 1'b0;
   endtask

   always @(negedge clock) begin
      if (!reset && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon1_extra got instr=%0h pc=%0h expected=none", instruction, pc);
         end else begin
            e = exp_q.pop_front();
            check("mon1_instr", 64'(instruction), 64'(e.instr));
            check("mon1_pc", 64'(pc), 64'(e.pc));
         end
      end
      if (!reset && instr_valid2 && instr_ready) begin
         if (exp2_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon2_extra got instr=%0h pc=%0h expected=none", instruction2, pc2);
         end else begin
            e = exp2_q.pop_front();
            check("mon2_instr", 64'(instruction2), 64'(e.instr));
            check("mon2_pc", 64'(pc2), 64'(e.pc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; en_write = 1'b0; addr_write = '0; data = '0;
      redirect = 1'b0; pc_src = 2'd0; addr_reg = '0; addr_jump = '0; addr_branch = '0;
      instr_ready = 1'b0;
      enable2 = 1'b0; en_write2 = 1'b0; addr_write2 = '0; redirect2 = 1'b0;
      addr_reg2 = '0; addr_jump2 = '0; addr_branch2 = '0;
      steps(2);
      check("rst_valid", 64'(instr_valid), 64'd0);
      check("rst_instr", 64'(instruction), 64'd0);
      check("rst_pc", 64'(pc), 64'd0);
      check("rst_halted", 64'(halted), 64'd0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 8; i++) wr(7'(4 * i), 32'h2000_0001 + 32'(i));
      wr(7'd32, HALT_WORD);

      // Streaming: first valid two edges after enable, then back to back until the halt.
      instr_ready = 1'b1;
      exp_stream(0);
      enable = 1'b1;
      step();
      check("lat_cycle1_valid", 64'(instr_valid), 64'd0);
      step();
      check("lat_cycle2_valid", 64'(instr_valid), 64'd1);
      for (int i = 0; i < 8; i++) begin
         step();
         check("stream_no_gap", 64'(instr_valid), 64'd1);
      end
      check("stream_halted", 64'(halted), 64'd1);
      step();
      check("halt_no_valid", 64'(instr_valid), 64'd0);
      steps(3);
      check("halt_still_idle", 64'(instr_valid), 64'd0);
      check("stream_drained", 64'(exp_q.size()), 64'd0);

      // Backpressure: queue fills, head holds, then drains in order.
      instr_ready = 1'b0;
      redirect_to(2'd0, 7'd0);
      check("redir_resume", 64'(halted), 64'd0);
      steps(2);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", 64'(instr_valid), 64'd1);
         check("bp_head_instr", 64'(instruction), 64'h2000_0001);
         check("bp_head_pc", 64'(pc), 64'd4);
         step();
      end
      exp_stream(0);
      instr_ready = 1'b1;
      steps(14);
      check("bp_drained", 64'(exp_q.size()), 64'd0);
      check("bp_halted", 64'(halted), 64'd1);

      // Jump while the queue is full: stale entries must vanish.
      instr_ready = 1'b0;
      redirect_to(2'd0, 7'd0);
      steps(8);
      redirect_to(2'd1, 7'd20);
      check("jump_gap_valid", 64'(instr_valid), 64'd0);
      exp_stream(20);
      instr_ready = 1'b1;
      steps(8);
      check("jump_drained", 64'(exp_q.size()), 64'd0);
      check("jump_halted", 64'(halted), 64'd1);

      // Reset mid-stream.
      redirect_to(2'd0, 7'd0);
      exp_push(32'h2000_0001, 7'd4);
      exp_push(32'h2000_0002, 7'd8);
      steps(4);
      reset  = 1'b1;
      enable = 1'b0;
      #1;
      check("rst_mid_valid", 64'(instr_valid), 64'd0);
      check("rst_mid_delivered", 64'(exp_q.size()), 64'd0);
      step();
      reset = 1'b0;
      step();
      check("rst_mid_halted", 64'(halted), 64'd0);
      exp_stream(0);
      enable = 1'b1;
      steps(14);
      check("rst_restart_drained", 64'(exp_q.size()), 64'd0);
      check("rst_restart_halted", 64'(halted), 64'd1);

      // Halt at address 12, then resume via register redirect.
      wr(7'd12, HALT_WORD);
      for (int r = 0; r < 2; r++) begin
         exp_push(32'h2000_0001, 7'd4);
         exp_push(32'h2000_0002, 7'd8);
         exp_push(32'h2000_0003, 7'd12);
         exp_push(HALT_WORD, 7'd16);
         redirect_to(2'd0, 7'd0);
         check("h12_resumed", 64'(halted), 64'd0);
         steps(8);
         check("h12_drained", 64'(exp_q.size()), 64'd0);
         check("h12_halted", 64'(halted), 64'd1);
         check("h12_no_valid", 64'(instr_valid), 64'd0);
      end

      // 4-bit address instance: PC wraps from 12 to 0.
      wr2(4'd0, 32'h0000_0011);
      wr2(4'd4, 32'h0000_0022);
      wr2(4'd8, HALT_WORD);
      wr2(4'd12, 32'h0000_0033);
      exp2_push(32'h0000_0033, 7'd0);
      exp2_push(32'h0000_0011, 7'd4);
      exp2_push(32'h0000_0022, 7'd8);
      exp2_push(HALT_WORD, 7'd12);
      enable2    = 1'b1;
      pc_src     = 2'd1;
      addr_jump2 = 4'd12;
      redirect2  = 1'b1;
      step();
      redirect2  = 1'b0;
      steps(8);
      check("wrap_drained", 64'(exp2_q.size()), 64'd0);
      check("wrap_halted", 64'(halted2), 64'd1);

      // Branch select (pc_src=3) on the same instance.
      exp2_push(32'h0000_0022, 7'd8);
      exp2_push(HALT_WORD, 7'd12);
      pc_src       = 2'd3;
      addr_branch2 = 4'd4;
      addr_jump2   = 4'd0;
      addr_reg2    = 4'd0;
      redirect2    = 1'b1;
      step();
      redirect2    = 1'b0;
      steps(6);
      check("branch_drained", 64'(exp2_q.size()), 64'd0);
      check("branch_halted", 64'(halted2), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
